// File: rtl/i2s_dac_transmitter_if.sv
// i2s_dac_transmitter_if: sample handshake between the waveform mux and the I2S transmitter
// sample_in    : WIDTH-bit two's complement sample, driven by the upstream mux
// sample_valid : sample_in is valid this cycle
// sample_ready : transmitter holding register is empty
interface i2s_dac_transmitter_if #(parameter int WIDTH = 24);
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             sample_ready;
  modport master (output sample_in, sample_valid, input sample_ready);
  modport slave  (input sample_in, sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_dac_transmitter.sv
// i2s_dac_transmitter: I2S master that sends one mono sample per frame on both channels
// clock       : system clock
// clear_n     : asynchronous active-low reset
// up          : sample handshake (slave side), one-entry holding register
// bclk        : bit clock, BCLK_HALF system clocks per half period
// lrclk       : word select, 0 = left, 1 = right
// sdata       : serial data, MSB one BCLK after the lrclk edge
// frame_start : pulse in the cycle a new frame word is loaded
// underrun    : pulse with frame_start when no new sample was held
module i2s_dac_transmitter #(
  parameter int WIDTH     = 24,
  parameter int SLOT      = 32,
  parameter int BCLK_HALF = 9
) (
  input  logic                   clock,
  input  logic                   clear_n,
  i2s_dac_transmitter_if.slave   up,
  output logic                   bclk,
  output logic                   lrclk,
  output logic                   sdata,
  output logic                   frame_start,
  output logic                   underrun
);
  localparam int DW = $clog2(BCLK_HALF);
  localparam int BW = $clog2(2 * SLOT);
  localparam int PW = $clog2(SLOT);
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt, nxt_bit;
  logic [PW-1:0]    p;
  logic [SLOT-1:0]  slot;
  logic [WIDTH-1:0] hold_reg, frame_word;
  logic             hold_full, tick, fall, wrap, xfer;
  always_comb begin
    tick    = div_cnt == DW'(BCLK_HALF - 1);
    fall    = tick && bclk;
    wrap    = fall && bit_cnt == BW'(2 * SLOT - 1);
    nxt_bit = (bit_cnt == BW'(2 * SLOT - 1)) ? '0 : bit_cnt + 1'b1;
    p       = PW'(nxt_bit % BW'(SLOT));
    // slot image: a leading zero bit (p = 0), the word MSB first, then zero padding
    slot    = SLOT'({1'b0, frame_word}) << (SLOT - 1 - WIDTH);
    xfer    = up.sample_valid && !hold_full;
  end
  assign up.sample_ready = ~hold_full;
  assign frame_start     = wrap;
  assign underrun        = wrap && !hold_full;
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      div_cnt    <= '0;
      bclk       <= 1'b0;
      bit_cnt    <= BW'(2 * SLOT - 1);
      lrclk      <= 1'b1;
      sdata      <= 1'b0;
      hold_full  <= 1'b0;
      hold_reg   <= '0;
      frame_word <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) bclk <= ~bclk;
      if (fall) begin
        bit_cnt <= nxt_bit;
        lrclk   <= nxt_bit >= BW'(SLOT);
        sdata   <= slot[PW'(SLOT - 1) - p];
      end
      if (wrap && hold_full) frame_word <= hold_reg;
      // ready is ~hold_full, so a transfer and a consuming load never share an edge
      if (xfer) begin
        hold_reg  <= up.sample_in;
        hold_full <= 1'b1;
      end else if (wrap) hold_full <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// tb_i2s_dac_transmitter: directed frame table plus random traffic against a timing/queue model
module tb_i2s_dac_transmitter;
  localparam int W = 24, S = 32, BH = 9, FR = 4 * S * BH;
  logic clock = 1'b0, clear_n = 1'b0;
  logic bclk, lrclk, sdata, frame_start, underrun;
  i2s_dac_transmitter_if #(.WIDTH(W)) up();
  i2s_dac_transmitter #(.WIDTH(W), .SLOT(S), .BCLK_HALF(BH)) dut (
    .clock(clock), .clear_n(clear_n), .up(up), .bclk(bclk), .lrclk(lrclk),
    .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
  );
  always #5 clock = ~clock;
  typedef struct { logic push; logic [W-1:0] val; logic ur; logic [W-1:0] w; } frame_t;
  frame_t tbl[7];
  int checks = 0, failures = 0;
  int c, fk;
  bit tbl_phase = 0, rnd_phase = 0, pre_full;
  logic [W-1:0] m_word;
  logic [W-1:0] q[$];
  logic [W-1:0] src_q[$];
  logic prev_bclk, rx_lr;
  logic [S-1:0] rx;
  int rx_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, c);
    end
  endtask

  function automatic int bpos(input int cc);
    return (cc >= 2 * BH) ? ((cc - 2 * BH) / (2 * BH)) % (2 * S) : -1;
  endfunction

  task automatic model_reset();
    c = 0; fk = 0; m_word = '0; q.delete(); src_q.delete();
    prev_bclk = 1'b0; rx_lr = 1'b1; rx_n = 0; rx = '0;
    if (tbl_phase) for (int i = 0; i < 3; i++) src_q.push_back(tbl[i].val);
  endtask

  task automatic step();
    int b, p;
    logic e_lr, e_sd, e_fs, e_ur, xfer;
    logic [W-1:0] t;
    logic [S-1:0] es;
    b = bpos(c);
    p = b % S;
    e_lr = (b < 0) ? 1'b1 : (b >= S);
    t = (b >= 0 && p >= 1 && p <= W) ? m_word >> (W - p) : '0;
    e_sd = t[0];
    e_fs = (c >= 2 * BH - 1) && ((c - (2 * BH - 1)) % FR == 0);
    e_ur = e_fs && q.size() == 0;
    pre_full = q.size() > 0;
    chk("bclk", bclk, (c / BH) % 2);
    chk("lrclk", lrclk, e_lr);
    chk("sdata", sdata, e_sd);
    chk("frame_start", frame_start, e_fs);
    chk("underrun", underrun, e_ur);
    chk("sample_ready", up.sample_ready, q.size() == 0);
    if (tbl_phase && e_fs && fk < 7) chk("tbl_underrun", underrun, tbl[fk].ur);
    if (bclk && !prev_bclk) begin
      if (lrclk !== rx_lr) begin rx_n = 0; rx_lr = lrclk; end
      rx = {rx[S-2:0], sdata};
      rx_n++;
      if (rx_n == S) begin
        es = S'({1'b0, (tbl_phase && fk > 0) ? tbl[fk-1].w : m_word}) << (S - 1 - W);
        chk(rx_lr ? "slot_right" : "slot_left", rx, es);
        rx_n = 0;
      end
    end
    prev_bclk = bclk;
    if (rnd_phase && src_q.size() == 0 && $urandom_range(999, 0) == 0) src_q.push_back(W'($urandom));
    up.sample_valid = src_q.size() > 0;
    up.sample_in = (src_q.size() > 0) ? src_q[0] : '0;
    xfer = up.sample_valid && q.size() == 0;
    if (up.sample_valid && up.sample_ready) void'(src_q.pop_front());
    if (e_fs) begin
      if (q.size() > 0) m_word = q.pop_front();
      if (tbl_phase && fk + 1 >= 3 && fk + 1 < 7 && tbl[fk+1].push) src_q.push_back(tbl[fk+1].val);
      fk++;
    end
    if (xfer) q.push_back(up.sample_in);
    c++;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_bclk"}, bclk, 0);
    chk({tag, "_lrclk"}, lrclk, 1);
    chk({tag, "_sdata"}, sdata, 0);
    chk({tag, "_ready"}, up.sample_ready, 1);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_underrun"}, underrun, 0);
  endtask

  task automatic release_rst();
    @(negedge clock);
    clear_n = 1'b1;
    model_reset();
    step();
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear_n = 1'b0;
    up.sample_valid = 1'b0;
    up.sample_in = '0;
    repeat (5) begin @(negedge clock); chk_rst("rst"); end
    release_rst();
  endtask

  task automatic run_until(input int target);
    while (c < target) begin @(negedge clock); step(); end
  endtask

  task automatic mid_reset();
    int n = 0;
    bit hit = 0;
    src_q.push_back(24'h123456);
    while (!hit && n < 3 * FR) begin
      @(negedge clock);
      step();
      n++;
      hit = pre_full && bpos(c - 1) == 10;
    end
    if (!hit) begin
      checks++; failures++;
      $display("FAIL mid_reset_wait actual=timeout expected=left_p10_with_hold_full cycle=%0d", c);
    end
    #2 clear_n = 1'b0;
    #1 chk_rst("async");
    repeat (3) begin @(negedge clock); chk_rst("mid"); end
    release_rst();
  endtask

  initial begin
    up.sample_valid = 1'b0;
    up.sample_in = '0;
    tbl[0] = '{1'b1, 24'hA5C30F, 1'b0, 24'hA5C30F};
    tbl[1] = '{1'b1, 24'h000001, 1'b0, 24'h000001};
    tbl[2] = '{1'b1, 24'h000002, 1'b0, 24'h000002};
    tbl[3] = '{1'b1, 24'h7FFFFF, 1'b0, 24'h7FFFFF};
    tbl[4] = '{1'b0, 24'h000000, 1'b1, 24'h7FFFFF};
    tbl[5] = '{1'b1, 24'h800000, 1'b0, 24'h800000};
    tbl[6] = '{1'b0, 24'h000000, 1'b1, 24'h800000};
    do_reset();
    run_until(2 * BH + 2);
    tbl_phase = 1;
    do_reset();
    run_until(2 * BH - 1 + 7 * FR);
    tbl_phase = 0;
    rnd_phase = 1;
    run_until(c + 6 * FR);
    rnd_phase = 0;
    mid_reset();
    run_until(4 * BH + FR);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2s_dac_transmitter.md
# i2s_dac_transmitter

Serializes the synthesizer's selected waveform sample, the 24-bit output of the waveform select mux, into an I2S stream for the board's audio DAC codec. The block is the I2S master: it generates BCLK and LRCLK from the system clock and pulls one mono sample per frame through a single-entry holding register with a valid/ready handshake. The same word is sent on both the left and right channels.

## Interface

Parameters:
- WIDTH, 24, sample width in bits, two's complement; must satisfy WIDTH <= SLOT-1
- SLOT, 32, BCLK periods per channel slot; a frame is 2*SLOT bits
- BCLK_HALF, 9, system clock cycles per BCLK half-period; must be >= 2

Ports:
- clock  in  1  system clock (50 MHz)
- clear_n  in  1  asynchronous active-low reset
- sample_in  in  WIDTH  sample from the waveform mux, signed
- sample_valid  in  1  sample_in is valid this cycle
- sample_ready  out  1  holding register empty; combinational, equal to ~hold_full
- bclk  out  1  I2S bit clock, registered
- lrclk  out  1  I2S word select, registered; 0 = left, 1 = right
- sdata  out  1  I2S serial data, registered, MSB first
- frame_start  out  1  one-cycle pulse when a new frame word is loaded
- underrun  out  1  one-cycle pulse, coincident with frame_start, when no new sample was available

## Operation

- Reset values (clear_n low, applied asynchronously):
  - div_cnt = 0, bclk = 0, bit_cnt = 2*SLOT-1, lrclk = 1, sdata = 0
  - hold_full = 0, so sample_ready = 1
  - hold_reg = 0, frame_word = 0, frame_start = 0, underrun = 0
- BCLK divider:
  - div_cnt counts 0 to BCLK_HALF-1.
  - At BCLK_HALF-1, bclk toggles and div_cnt returns to 0.
  - A "fall tick" is the cycle in which bclk toggles from 1 to 0.
- Bit counter: bit_cnt advances modulo 2*SLOT on every fall tick. No other event changes it.
- Slot position: p = bit_cnt mod SLOT. On each fall tick, lrclk and sdata are registered from the new bit_cnt:
  - lrclk = (bit_cnt >= SLOT)
  - sdata = frame_word[WIDTH-p] for p in 1..WIDTH
  - sdata = 0 for p = 0 and for p > WIDTH
  - This is standard I2S: the MSB follows the LRCLK edge by one BCLK.
- Frame load, on the fall tick where bit_cnt wraps 2*SLOT-1 to 0:
  - If hold_full: frame_word <= hold_reg, hold_full <= 0.
  - Otherwise: frame_word is kept (the last sample repeats) and underrun = 1.
  - frame_start = 1 in this cycle in both cases.
  - sdata for p = 0 is 0, so the new word is not needed until the next fall tick.
- Handshake:
  - A transfer occurs when sample_valid && sample_ready at a rising edge of clock.
  - On transfer: hold_reg <= sample_in, hold_full <= 1.
  - sample_valid while sample_ready = 0 is ignored. Upstream must hold its data.
- Simultaneous load and transfer:
  - Since ready = ~hold_full, a transfer in a frame-load cycle only happens when the holding register was empty.
  - In that case underrun fires, frame_word is unchanged, and hold_full becomes 1 at that edge.
- Mono: the left and right slots of a frame carry the identical frame_word.

## Timing

- BCLK period is 2*BCLK_HALF clocks.
- A frame is 4*SLOT*BCLK_HALF clocks; with the defaults this is 1152 clocks, 43.40 kHz at 50 MHz.
- After clear_n deasserts:
  - first bclk rise occurs at the end of cycle BCLK_HALF-1
  - first fall tick occurs at cycle 2*BCLK_HALF-1
  - this first fall tick is a frame load, so frame_start = 1, and underrun = 1 unless a sample was accepted earlier
- bclk, lrclk and sdata all change on the same clock edge (the fall tick). Data is stable across every bclk rising edge for at least BCLK_HALF clocks.
- frame_start and underrun are high for exactly one clock.
- sample_ready rises in the clock after a frame load that consumes hold_reg.
- Handshake latency is 1 cycle from valid to ready low.
- A mid-frame reset aborts the frame immediately: outputs go to their reset values and the held sample is discarded.

## Test plan

- Reset/startup: hold clear_n low for 5 cycles, then release with sample_valid = 0.
  - During reset: bclk = 0, lrclk = 1, sdata = 0, sample_ready = 1.
  - bclk rises after cycle 8 and falls after cycle 17.
  - At cycle 17: frame_start = 1, underrun = 1, lrclk = 0.
- Basic frame: present 24'hA5C30F with valid before the first fall tick.
  - At the first frame load: underrun = 0.
  - Left slot: p0 = 0, p1..p24 = 1010_0101_1100_0011_0000_1111, p25..p31 = 0.
  - Right slot (lrclk = 1): identical bits.
- Backpressure: drive valid continuously with 24'h000001, then 24'h000002.
  - First word accepted; sample_ready stays 0 until the next frame load.
  - Second word accepted one cycle after that frame_start.
  - The following frame carries 24'h000002.
- Underrun repeat: after the frame carrying 24'h7FFFFF, supply no sample.
  - Next frame: underrun = 1 for one cycle, and the stream repeats 0 followed by 23 ones.
- Negative full-scale: load 24'h800000.
  - p1 = 1, p2..p24 = 0 in both slots.
- Reset mid-frame: assert clear_n at left-slot p = 10 with hold_full = 1.
  - Outputs go to reset values without waiting for a clock edge; sample_ready = 1.
  - After release, the first frame has underrun = 1 and frame_word = 0.
